// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction packet FIFO with single-cycle flush.
// Optional same-cycle empty bypass is enabled by defining IFQ_BYPASS_EN.

package lc3b_pkg;
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } lc3b_ipacket;
endpackage

module if_id_buffer
  import lc3b_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              enq_valid,
  input  lc3b_ipacket       enq_packet,
  output logic              enq_ready,
  output logic              deq_valid,
  output lc3b_ipacket       deq_packet,
  input  logic              deq_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  lc3b_ipacket      storage [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  lc3b_ipacket      head_pkt;
  logic             bypass;
  logic             push;
  logic             pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = ~full;

`ifdef IFQ_BYPASS_EN
  assign bypass     = empty & enq_valid & deq_ready & ~flush;
  assign deq_valid  = ~empty | bypass;
  assign deq_packet = bypass ? enq_packet : head_pkt;
`else
  assign bypass     = 1'b0;
  assign deq_valid  = ~empty;
  assign deq_packet = head_pkt;
`endif

  assign push = enq_valid & enq_ready & ~bypass & ~flush;
  assign pop  = deq_ready & ~empty & ~flush;

  // Storage is deliberately left unreset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      storage[tail] <= enq_packet;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      head_pkt <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      head_pkt <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // The registered head copy tracks whichever entry will be oldest after this edge.
      if (pop) begin
        if (count > CNT_W'(1)) begin
          head_pkt <= storage[head + 1'b1];
        end else if (push) begin
          head_pkt <= enq_packet;
        end
      end else if (push && empty) begin
        head_pkt <= enq_packet;
      end
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomised and directed scoreboard bench for if_id_buffer using a queue model.

module tb_if_id_buffer;
  import lc3b_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              enq_valid = 1'b0;
  lc3b_ipacket       enq_packet = '0;
  logic              enq_ready;
  logic              deq_valid;
  lc3b_ipacket       deq_packet;
  logic              deq_ready = 1'b0;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  int checks = 0;
  int fails  = 0;
  lc3b_ipacket exp_q[$];
  bit mon_bp;

  if_id_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_packet(enq_packet), .enq_ready(enq_ready),
    .deq_valid(deq_valid), .deq_packet(deq_packet), .deq_ready(deq_ready),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue following the push/pop/flush rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      automatic bit was_empty = (exp_q.size() == 0);
      automatic bit do_pop  = deq_ready && !was_empty;
      automatic bit do_push = enq_valid && (exp_q.size() < DEPTH);
`ifdef IFQ_BYPASS_EN
      if (was_empty && enq_valid && deq_ready) do_push = 0;
`endif
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(enq_packet);
    end
  end

  // Monitor: compares visible outputs against the model after every edge.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_bp = 0;
`ifdef IFQ_BYPASS_EN
      mon_bp = (exp_q.size() == 0) && enq_valid && deq_ready && !flush;
`endif
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("enq_ready", 32'(enq_ready), 32'(exp_q.size() != DEPTH));
      chk("deq_valid", 32'(deq_valid), 32'(exp_q.size() != 0 || mon_bp));
      if (mon_bp) chk("bypass_pkt", 32'(deq_packet), 32'(enq_packet));
      else if (exp_q.size() != 0) chk("head_pkt", 32'(deq_packet), 32'(exp_q[0]));
    end
  end

  task automatic drive(input logic ev, input logic [15:0] pc, input logic dr, input logic fl);
    @(negedge clk);
    #1;
    enq_valid  = ev;
    enq_packet = '{pc: pc, instr: 16'($urandom)};
    deq_ready  = dr;
    flush      = fl;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
    chk({tag, "_deq_valid"}, 32'(deq_valid), 32'd0);
    chk({tag, "_deq_packet"}, 32'(deq_packet), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check_reset_values("por");
    rst_n = 1'b1;

    // Fill, overfill attempt, then drain in order.
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h3000 + 16'(2 * i), 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);

    // Simultaneous push and pop with two entries held.
    drive(1'b1, 16'h4100, 1'b0, 1'b0);
    drive(1'b1, 16'h4102, 1'b0, 1'b0);
    drive(1'b1, 16'h4000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h5100 + 16'(2 * i), 1'b0, 1'b0);
    drive(1'b1, 16'h5000, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);

    // Ten push/pop pairs across the pointer wrap.
    for (int i = 0; i < 10; i++) drive(1'b1, 16'h7000 + 16'(2 * i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);

`ifdef IFQ_BYPASS_EN
    drive(1'b1, 16'h6000, 1'b1, 1'b0);
    #2;
    chk("bypass_same_cycle_valid", 32'(deq_valid), 32'd1);
    chk("bypass_same_cycle_pc", 32'(deq_packet.pc), 32'h6000);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a cycle with entries held.
    drive(1'b1, 16'h8000, 1'b0, 1'b0);
    drive(1'b1, 16'h8002, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 4));
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
